// File: rtl/bytecode_loader.sv
// Program-memory loader: writes a host byte stream to consecutive addresses after a load command.
// Latency: a byte accepted into an empty buffer is presented to memory on the next cycle.
// Backpressure: byte_ready drops when the buffer is full or the byte count is reached; mem_ready stalls hold address/data.

// Small synchronous FIFO used to decouple the input stream from memory stalls.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: the caller must not push when full or pop when empty.
module bytecode_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_cnt;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];

  // Storage, pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_dat;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// Loader top: IDLE/LOAD/DONE sequencer, byte counters, wrapping write pointer.
// Latency: done pulses the cycle after the final memory write; len_err the cycle after a rejected command.
// Backpressure: input throttled by buffer space and remaining count; memory side waits on mem_ready.
module bytecode_loader #(
  parameter int RAM_SIZE      = 256,
  parameter int ADDRESS_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_start,
  input  logic [ADDRESS_WIDTH-1:0] load_base,
  input  logic [ADDRESS_WIDTH:0]   load_len,
  output logic                     busy,
  output logic                     done,
  output logic                     len_err,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [7:0]               mem_data_out,
  output logic                     mem_rwn,
  output logic                     mem_start,
  input  logic                     mem_ready
);
  localparam logic [ADDRESS_WIDTH:0]   L_RAM_SIZE = (ADDRESS_WIDTH+1)'(RAM_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] L_LAST     = ADDRESS_WIDTH'(RAM_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH:0]   r_len;
  logic [ADDRESS_WIDTH:0]   r_accepted;
  logic [ADDRESS_WIDTH:0]   r_written;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic                     r_len_err;

  logic       w_len_bad;
  logic       w_cmd_go;
  logic       w_push;
  logic       w_pop;
  logic       w_last_write;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;

  // Commands are only looked at while idle; zero-length goes straight to DONE without latching.
  assign w_len_bad    = (r_state == S_IDLE) && cmd_start && (load_len > L_RAM_SIZE);
  assign w_cmd_go     = (r_state == S_IDLE) && cmd_start && !(load_len > L_RAM_SIZE) && (load_len != '0);

  assign byte_ready   = (r_state == S_LOAD) && !w_full && (r_accepted < r_len);
  assign w_push       = byte_valid && byte_ready;
  assign mem_start    = (r_state == S_LOAD) && !w_empty;
  assign w_pop        = mem_start && mem_ready;
  assign w_last_write = w_pop && ((r_written + 1'b1) == r_len);

  assign mem_address  = r_ptr;
  assign mem_data_out = w_head;
  assign mem_rwn      = 1'b0;
  assign len_err      = r_len_err;

  bytecode_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (byte_in),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_start && !(load_len > L_RAM_SIZE))
          w_state_nxt = (load_len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (w_last_write) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Length latch, byte counters, write pointer with RAM_SIZE wrap, and the reject pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_ptr      <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= w_len_bad;
      if (w_cmd_go) begin
        r_len      <= load_len;
        r_ptr      <= load_base;
        r_accepted <= '0;
        r_written  <= '0;
      end else begin
        if (w_push) r_accepted <= r_accepted + 1'b1;
        if (w_pop) begin
          r_written <= r_written + 1'b1;
          r_ptr     <= (r_ptr == L_LAST) ? '0 : r_ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bytecode_loader.sv
// Bench for bytecode_loader: directed scenarios plus randomized loads checked against
// an address/data model ((base+i) mod RAM_SIZE, i-th stream byte) and cycle-stamped monitor logs.
module tb_bytecode_loader;
  localparam int RAM = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_start;
  logic [7:0] load_base;
  logic [8:0] load_len;
  logic       busy, done, len_err;
  logic [7:0] byte_in;
  logic       byte_valid, byte_ready;
  logic [7:0] mem_address, mem_data_out;
  logic       mem_rwn, mem_start, mem_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] stream [512];
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int acc_cyc_q[$];
  int done_cnt;
  int done_cyc;
  int err_cnt;

  bytecode_loader #(.RAM_SIZE(256), .ADDRESS_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .load_base(load_base), .load_len(load_len),
    .busy(busy), .done(done), .len_err(len_err), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_rwn(mem_rwn), .mem_start(mem_start), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log completed writes, accepted bytes and status pulses mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_start && mem_ready) begin
        wr_addr_q.push_back(int'(mem_address));
        wr_data_q.push_back(int'(mem_data_out));
        wr_cyc_q.push_back(cyc);
      end
      if (byte_valid && byte_ready) acc_cyc_q.push_back(cyc);
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (len_err) err_cnt = err_cnt + 1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
    done_cnt = 0;
    done_cyc = 0;
    err_cnt  = 0;
  endtask

  task automatic fill_stream(input int n);
    for (int i = 0; i < n; i++) stream[i] = 8'($urandom_range(255));
  endtask

  // Issues a command and feeds the stream until done is seen or the budget runs out.
  task automatic drive_load(input logic [7:0] base, input logic [8:0] len, input int nbytes,
                            input int vpct, input int rpct, input int budget, output bit timeout);
    int idx;
    bit fin;
    idx = 0;
    fin = 0;
    @(posedge clk); #1;
    cmd_start = 1'b1; load_base = base; load_len = len; byte_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int k = 0; k < budget && !fin; k++) begin
      byte_valid = (idx < nbytes) && (int'($urandom_range(99)) < vpct);
      byte_in    = stream[idx];
      mem_ready  = (int'($urandom_range(99)) < rpct);
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      if (done) fin = 1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    mem_ready  = 1'b0;
    timeout    = !fin;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_start = 1'b0; load_base = '0; load_len = '0;
    byte_in = '0; byte_valid = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (len_err !== 1'b0)      begin bad++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    total++; if (byte_ready !== 1'b0)   begin bad++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    total++; if (mem_start !== 1'b0)    begin bad++; $display("FAIL reset_mem_start: got %b want 0", mem_start); end
    total++; if (mem_address !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", mem_address); end
    total++; if (mem_data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", mem_data_out); end
    total++; if (mem_rwn !== 1'b0)      begin bad++; $display("FAIL reset_rwn: got %b want 0", mem_rwn); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    bit to;
    stream[0] = 8'hA1; stream[1] = 8'hB2; stream[2] = 8'hC3;
    clear_mon();
    drive_load(8'h10, 9'd3, 3, 100, 100, 50, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: no done within budget"); end
    total++; if (wr_addr_q.size() !== 3) begin bad++; $display("FAIL basic_count: got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      total++; if (wr_addr_q[i] !== 16 + i) begin bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, wr_addr_q[i], 16 + i); end
      total++; if (wr_data_q[i] !== int'(stream[i])) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, wr_data_q[i], stream[i]); end
      total++; if (wr_cyc_q[i] !== wr_cyc_q[0] + i) begin bad++; $display("FAIL basic_consec[%0d]: got %0d want %0d", i, wr_cyc_q[i], wr_cyc_q[0] + i); end
    end
    if (wr_cyc_q.size() == 3 && acc_cyc_q.size() > 0) begin
      total++; if (wr_cyc_q[0] !== acc_cyc_q[0] + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", wr_cyc_q[0], acc_cyc_q[0] + 1); end
      total++; if (done_cyc !== wr_cyc_q[2] + 1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, wr_cyc_q[2] + 1); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int idx;
    int unstable;
    bit fin;
    fill_stream(6);
    clear_mon();
    idx = 0; unstable = 0; fin = 0;
    @(posedge clk); #1;
    cmd_start = 1'b1; load_base = 8'h30; load_len = 9'd6; mem_ready = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      byte_valid = (idx < 6); byte_in = stream[idx]; mem_ready = 1'b0;
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      if (k >= 1 && (mem_start !== 1'b1 || mem_address !== 8'h30 || mem_data_out !== stream[0])) unstable++;
      if (k == 9) begin
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", byte_ready); end
      end
      @(posedge clk); #1;
    end
    total++; if (idx !== 4)      begin bad++; $display("FAIL bp_buffered: got %0d want 4", idx); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
    for (int k = 0; k < 40 && !fin; k++) begin
      byte_valid = (idx < 6); byte_in = stream[idx]; mem_ready = 1'b1;
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      if (done) fin = 1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0; mem_ready = 1'b0;
    total++; if (!fin) begin bad++; $display("FAIL bp_timeout: no done within budget"); end
    total++; if (wr_addr_q.size() !== 6) begin bad++; $display("FAIL bp_count: got %0d want 6", wr_addr_q.size()); end
    for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
      total++; if (wr_addr_q[i] !== 48 + i) begin bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, wr_addr_q[i], 48 + i); end
      total++; if (wr_data_q[i] !== int'(stream[i])) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, wr_data_q[i], stream[i]); end
      total++; if (wr_cyc_q[i] !== wr_cyc_q[0] + i) begin bad++; $display("FAIL bp_consec[%0d]: got %0d want %0d", i, wr_cyc_q[i], wr_cyc_q[0] + i); end
    end
  endtask

  task automatic test_wrap_limits();
    bit to;
    fill_stream(4);
    clear_mon();
    drive_load(8'hFE, 9'd4, 4, 70, 70, 200, to);
    total++; if (to) begin bad++; $display("FAIL wrap_timeout: no done within budget"); end
    total++; if (wr_addr_q.size() !== 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      total++; if (wr_addr_q[i] !== (254 + i) % RAM) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, wr_addr_q[i], (254 + i) % RAM); end
      total++; if (wr_data_q[i] !== int'(stream[i])) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wr_data_q[i], stream[i]); end
    end
    // zero length
    clear_mon();
    @(posedge clk); #1;
    cmd_start = 1'b1; load_base = 8'h55; load_len = 9'd0;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b1)      begin bad++; $display("FAIL zero_done: got %b want 1", done); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL zero_mem_start: got %b want 0", mem_start); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    total++; if (wr_addr_q.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", wr_addr_q.size()); end
    // oversize length
    clear_mon();
    @(posedge clk); #1;
    cmd_start = 1'b1; load_base = 8'h00; load_len = 9'd257;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    @(negedge clk);
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL lenerr_pulse: got %b want 1", len_err); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL lenerr_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (len_err !== 1'b0)    begin bad++; $display("FAIL lenerr_one_cycle: got %b want 0", len_err); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL lenerr_busy2: got %b want 0", busy); end
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL lenerr_ready: got %b want 0", byte_ready); end
    total++; if (done_cnt !== 0)      begin bad++; $display("FAIL lenerr_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_oversupply();
    int idx;
    bit fin;
    fill_stream(5);
    clear_mon();
    idx = 0; fin = 0;
    @(posedge clk); #1;
    cmd_start = 1'b1; load_base = 8'h20; load_len = 9'd2; mem_ready = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      byte_valid = (idx < 5); byte_in = stream[idx]; mem_ready = 1'b0;
      cmd_start = (k == 2); load_base = 8'h80; load_len = 9'd5;
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      @(posedge clk); #1;
    end
    cmd_start = 1'b0;
    @(negedge clk);
    total++; if (idx !== 2)           begin bad++; $display("FAIL over_accepted: got %0d want 2", idx); end
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL over_ready: got %b want 0", byte_ready); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL over_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    for (int k = 0; k < 20 && !fin; k++) begin
      byte_valid = (idx < 5); byte_in = stream[idx]; mem_ready = 1'b1;
      @(negedge clk);
      if (byte_valid && byte_ready) idx++;
      if (done) fin = 1;
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0; mem_ready = 1'b0;
    total++; if (!fin) begin bad++; $display("FAIL over_timeout: no done within budget"); end
    total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL over_writes: got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      total++; if (wr_addr_q[i] !== 32 + i) begin bad++; $display("FAIL over_addr[%0d]: got %h want %h", i, wr_addr_q[i], 32 + i); end
      total++; if (wr_data_q[i] !== int'(stream[i])) begin bad++; $display("FAIL over_data[%0d]: got %h want %h", i, wr_data_q[i], stream[i]); end
    end
    total++; if (acc_cyc_q.size() !== 2) begin bad++; $display("FAIL over_acc_total: got %0d want 2", acc_cyc_q.size()); end
    total++; if (done_cnt !== 1)         begin bad++; $display("FAIL over_done_count: got %0d want 1", done_cnt); end
    total++; if (mem_address !== 8'h22)  begin bad++; $display("FAIL over_ignored_cmd: got %h want 22", mem_address); end
  endtask

  task automatic test_reset_midload();
    int nw;
    bit to;
    fill_stream(8);
    clear_mon();
    nw = 0;
    @(posedge clk); #1;
    cmd_start = 1'b1; load_base = 8'h50; load_len = 9'd8; mem_ready = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int k = 0; k < 40 && nw < 3; k++) begin
      byte_valid = 1'b1; byte_in = stream[k % 8]; mem_ready = 1'b1;
      @(negedge clk);
      if (mem_start && mem_ready) nw++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (mem_start !== 1'b0)    begin bad++; $display("FAIL rst_mem_start: got %b want 0", mem_start); end
    total++; if (byte_ready !== 1'b0)   begin bad++; $display("FAIL rst_ready: got %b want 0", byte_ready); end
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (mem_address !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", mem_address); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0; mem_ready = 1'b0;
    total++; if (wr_addr_q.size() !== 3) begin bad++; $display("FAIL rst_prior_writes: got %0d want 3", wr_addr_q.size()); end
    total++; if (done_cnt !== 0)         begin bad++; $display("FAIL rst_no_done: got %0d want 0", done_cnt); end
    fill_stream(2);
    clear_mon();
    drive_load(8'h40, 9'd2, 2, 100, 100, 50, to);
    total++; if (to) begin bad++; $display("FAIL rst_reload_timeout: no done within budget"); end
    total++; if (wr_addr_q.size() !== 2) begin bad++; $display("FAIL rst_reload_count: got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      total++; if (wr_addr_q[i] !== 64 + i) begin bad++; $display("FAIL rst_reload_addr[%0d]: got %h want %h", i, wr_addr_q[i], 64 + i); end
      total++; if (wr_data_q[i] !== int'(stream[i])) begin bad++; $display("FAIL rst_reload_data[%0d]: got %h want %h", i, wr_data_q[i], stream[i]); end
    end
    if (wr_cyc_q.size() == 2) begin
      total++; if (wr_cyc_q[1] !== wr_cyc_q[0] + 1) begin bad++; $display("FAIL rst_reload_consec: got %0d want %0d", wr_cyc_q[1], wr_cyc_q[0] + 1); end
      total++; if (done_cyc !== wr_cyc_q[1] + 1)    begin bad++; $display("FAIL rst_reload_done_cycle: got %0d want %0d", done_cyc, wr_cyc_q[1] + 1); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rst_reload_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_loads();
    bit to;
    int base, len, vp, rp;
    for (int it = 0; it < 25; it++) begin
      base = $urandom_range(255);
      len  = (it == 0) ? 256 : $urandom_range(24, 1);
      vp   = (it == 0) ? 100 : $urandom_range(100, 30);
      rp   = (it == 0) ? 100 : $urandom_range(100, 30);
      fill_stream(len + 3);
      clear_mon();
      drive_load(8'(base), 9'(len), len + $urandom_range(3), vp, rp, len * 20 + 50, to);
      total++; if (to) begin bad++; $display("FAIL rand%0d_timeout: no done within budget", it); end
      total++; if (wr_addr_q.size() !== len) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, wr_addr_q.size(), len); end
      total++; if (acc_cyc_q.size() !== len) begin bad++; $display("FAIL rand%0d_accepted: got %0d want %0d", it, acc_cyc_q.size(), len); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt); end
      for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
        total++; if (wr_addr_q[i] !== (base + i) % RAM) begin bad++; $display("FAIL rand%0d_addr[%0d]: got %h want %h", it, i, wr_addr_q[i], (base + i) % RAM); end
        total++; if (wr_data_q[i] !== int'(stream[i])) begin bad++; $display("FAIL rand%0d_data[%0d]: got %h want %h", it, i, wr_data_q[i], stream[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_wrap_limits();
    test_oversupply();
    test_reset_midload();
    test_random_loads();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bytecode_loader.md
Name: bytecode_loader

Overview:
- Write-side counterpart of the bytecode fetch path. It accepts a byte stream from the host/JIT side and writes it into program memory over the same start/ready memory port that the fetch unit reads.
- After a load command, the block writes `load_len` bytes starting at `load_base`, incrementing the address after each write. It then signals done.
- A small internal FIFO decouples the input stream from memory latency.

Parameters:
- RAM_SIZE, 256, number of program-memory bytes.
- ADDRESS_WIDTH, 8, memory address width.
- FIFO_DEPTH, 4, input buffer depth in bytes (power of 2, ≥2).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_start  input  1  one-cycle load request, sampled only in IDLE
- load_base  input  ADDRESS_WIDTH  first write address, latched on accepted cmd_start
- load_len  input  ADDRESS_WIDTH+1  byte count 0..RAM_SIZE, latched on accepted cmd_start
- busy  output  1  high from accepted command until DONE cycle
- done  output  1  one-cycle pulse, load complete
- len_err  output  1  one-cycle pulse, command rejected (load_len > RAM_SIZE)
- byte_in  input  8  stream data
- byte_valid  input  1  stream data valid
- byte_ready  output  1  loader can take byte_in this cycle
- mem_address  output  ADDRESS_WIDTH  write address
- mem_data_out  output  8  write data
- mem_rwn  output  1  constant 0 (write)
- mem_start  output  1  write request
- mem_ready  input  1  memory accepts write this cycle

Behaviour:
- Reset values:
  - state IDLE.
  - busy=0, done=0, len_err=0, byte_ready=0, mem_start=0.
  - mem_address=0, mem_data_out=0.
  - FIFO empty; all counters 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE, cmd_start=1:
  - load_len > RAM_SIZE: len_err=1 next cycle, stay IDLE.
  - load_len = 0: go to DONE (done pulses next cycle, no writes).
  - otherwise: latch base and len, clear accepted/written counters, go to LOAD, busy=1 next cycle.
- cmd_start outside IDLE is ignored.
- Input handshake:
  - byte_ready = (state==LOAD) && FIFO not full && accepted < len.
  - A byte is pushed when byte_valid && byte_ready; accepted increments.
  - Bytes beyond len are never taken.
- Memory handshake:
  - mem_start = (state==LOAD) && FIFO not empty.
  - mem_data_out = FIFO head; mem_address = current write pointer.
  - A write completes on a cycle with mem_start && mem_ready. On that cycle the FIFO pops, written increments, and the pointer advances.
  - Address and data are held stable while mem_start=1 and mem_ready=0.
- Pointer wrap: after RAM_SIZE-1 the pointer goes to 0 (not 2^ADDRESS_WIDTH when RAM_SIZE is smaller).
- FIFO may push and pop in the same cycle; occupancy is then unchanged.
- Latency: a byte accepted in cycle N appears on mem_start/mem_data_out in cycle N+1 if the FIFO was empty.
- Throughput: 1 byte/cycle when byte_valid=1 and mem_ready=1 continuously.
- Completion: on the write cycle where written reaches len, go to DONE. The FIFO is empty by construction.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Reset asserted mid-LOAD:
  - Next cycle all outputs return to reset values and the FIFO is flushed.
  - Any in-flight write is abandoned (mem_start=0).
  - No done pulse.
- Counters are ADDRESS_WIDTH+1 bits, so len=RAM_SIZE is representable.

Test Plan:
- Basic load: base=0x10, len=3, stream 0xA1,0xB2,0xC3, mem_ready=1. Required:
  - writes to 0x10/0x11/0x12 with those data on consecutive cycles;
  - done pulses one cycle after the last write; busy low after done.
- Backpressure: len=6, mem_ready=0 for 10 cycles. Required:
  - byte_ready drops after 4 bytes buffered;
  - mem_address/mem_data_out stable;
  - on mem_ready=1, all 6 bytes written in order, one per cycle.
- Wrap and limits, RAM_SIZE=256:
  - base=0xFE, len=4 writes 0xFE,0xFF,0x00,0x01.
  - len=0 gives done next cycle with no mem_start.
  - len=257 gives len_err pulse, busy stays 0.
- Over-supply and ignored command: len=2, stream of 5 valid bytes. Required:
  - only 2 accepted, byte_ready=0 thereafter;
  - cmd_start during LOAD has no effect.
- Reset mid-load: len=8, assert reset after 3 writes. Required:
  - next cycle busy=0, mem_start=0, byte_ready=0, no done pulse;
  - a following load with base=0x40, len=2 behaves as in the basic load test.
